// File: rtl/factor_game_pkg.sv
// factor_game_pkg: display state codes and lookup tables
// shared by the quiz sequencer and the 7-segment decoder.
package factor_game_pkg;

  typedef enum logic [3:0] {
    ST_READY    = 4'b0010,
    ST_QUESTION = 4'b0011,
    ST_INPUT    = 4'b0100,
    ST_CORRECT  = 4'b0111,
    ST_WRONG    = 4'b1000
  } state_t;

  typedef enum logic [1:0] {
    JG_STAY,
    JG_HIT,
    JG_MISS
  } judge_t;

  localparam logic [3:0] QMAX = 4'd9;
  localparam logic [3:0] SMAX = 4'd15;

  // key code to prime; 0 marks an illegal key
  function automatic logic [3:0] prime(input logic [3:0] k);
    case (k)
      4'd1:    prime = 4'd2;
      4'd2:    prime = 4'd3;
      4'd3:    prime = 4'd5;
      4'd4:    prime = 4'd7;
      default: prime = 4'd0;
    endcase
  endfunction

  // product the player must reach for each question
  function automatic logic [9:0] target(input logic [3:0] q);
    case (q)
      4'd0:    target = 10'd6;
      4'd1:    target = 10'd10;
      4'd2:    target = 10'd15;
      4'd3:    target = 10'd12;
      4'd4:    target = 10'd21;
      4'd5:    target = 10'd30;
      4'd6:    target = 10'd35;
      4'd7:    target = 10'd42;
      4'd8:    target = 10'd18;
      default: target = 10'd70;
    endcase
  endfunction

endpackage

// File: rtl/factor_game_ctrl_if.sv
// factor_game_ctrl_if: key/button inputs and display
// outputs of the quiz sequencer.
interface factor_game_ctrl_if;
  logic       START;
  logic       KEY_VALID;
  logic [3:0] KEY;
  logic [3:0] STATE;
  logic [3:0] QUE;
  logic [3:0] DIN;
  logic [3:0] SCORE;

  modport master (
    output START, KEY_VALID, KEY,
    input  STATE, QUE, DIN, SCORE
  );

  modport slave (
    input  START, KEY_VALID, KEY,
    output STATE, QUE, DIN, SCORE
  );
endinterface

// File: rtl/factor_game_timer.sv
// factor_game_timer: loadable down-counter shared by
// every phase of the quiz; stops at zero.
module factor_game_timer #(
  parameter int TW = 28
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] val,
  output logic          zero
);

  logic [TW-1:0] cnt;

  assign zero = (cnt == '0);

  // load wins; otherwise count down and hold at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (!zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/factor_game_ctrl.sv
// factor_game_ctrl: quiz sequencer; judges prime-factor
// key entries against the target table and keeps score.
module factor_game_ctrl
  import factor_game_pkg::*;
#(
  parameter int Q_SHOW_CYC  = 50_000_000,
  parameter int TIMEOUT_CYC = 250_000_000,
  parameter int HOLD_CYC    = 100_000_000,
  parameter int TW          = 28
) (
  input logic               CLK,
  input logic               nRST,
  factor_game_ctrl_if.slave bus
);

  localparam logic [TW-1:0] LD_Q =
    TW'(Q_SHOW_CYC - 1);
  localparam logic [TW-1:0] LD_TO =
    TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] LD_HOLD =
    TW'(HOLD_CYC - 1);

  state_t      state;
  logic [3:0]  que;
  logic [3:0]  din;
  logic [3:0]  score;
  logic [9:0]  acc;

  logic [3:0]  pk;
  logic [9:0]  acc_n;
  logic [9:0]  tgt;
  judge_t      verdict;

  logic          t_load;
  logic [TW-1:0] t_val;
  logic          t_zero;

  factor_game_timer #(
    .TW (TW)
  ) u_timer (
    .clk   (CLK),
    .rst_n (nRST),
    .load  (t_load),
    .val   (t_val),
    .zero  (t_zero)
  );

  assign bus.STATE = state;
  assign bus.QUE   = que;
  assign bus.DIN   = din;
  assign bus.SCORE = score;

  // judge the presented key against the running product
  always_comb begin
    pk      = prime(bus.KEY);
    acc_n   = acc * {6'd0, pk};
    tgt     = target(que);
    verdict = JG_STAY;
    unique case (1'b1)
      (pk == 4'd0):   verdict = JG_MISS;
      (acc_n == tgt): verdict = JG_HIT;
      (acc_n > tgt):  verdict = JG_MISS;
      default:        verdict = JG_STAY;
    endcase
  end

  // pick the timer reload for the phase being entered
  always_comb begin
    t_load = 1'b0;
    t_val  = '0;
    unique case (state)
      ST_READY: begin
        if (bus.START) begin
          t_load = 1'b1;
          t_val  = LD_Q;
        end
      end
      ST_QUESTION: begin
        if (t_zero) begin
          t_load = 1'b1;
          t_val  = LD_TO;
        end
      end
      ST_INPUT: begin
        if (bus.KEY_VALID) begin
          t_load = 1'b1;
          t_val  = (verdict == JG_STAY) ?
                   LD_TO : LD_HOLD;
        end else if (t_zero) begin
          t_load = 1'b1;
          t_val  = LD_HOLD;
        end
      end
      default: begin
        t_load = 1'b0;
      end
    endcase
  end

  // game FSM with score, question and entry registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= ST_READY;
      que   <= 4'd0;
      din   <= 4'd0;
      score <= 4'd0;
      acc   <= 10'd1;
    end else begin
      unique case (state)
        ST_READY: begin
          if (bus.START) begin
            state <= ST_QUESTION;
            acc   <= 10'd1;
            din   <= 4'd0;
          end
        end
        ST_QUESTION: begin
          if (t_zero) state <= ST_INPUT;
        end
        ST_INPUT: begin
          if (bus.KEY_VALID) begin
            din <= bus.KEY;
            unique case (verdict)
              JG_HIT: begin
                state <= ST_CORRECT;
                if (score != SMAX)
                  score <= score + 4'd1;
                que <= (que == QMAX) ?
                       4'd0 : que + 4'd1;
              end
              JG_MISS: state <= ST_WRONG;
              default: acc <= acc_n;
            endcase
          end else if (t_zero) begin
            state <= ST_WRONG;
          end
        end
        ST_CORRECT, ST_WRONG: begin
          if (t_zero) state <= ST_READY;
        end
        default: state <= ST_READY;
      endcase
    end
  end

endmodule

// File: tb/tb_factor_game_ctrl.sv
// tb_factor_game_ctrl: randomized rounds against a game-level
// model; a monitor scores every change seen on the outputs.
module tb_factor_game_ctrl;

  localparam int Q = 4;
  localparam int T = 8;
  localparam int H = 3;

  localparam logic [3:0] S_RDY = 4'b0010;
  localparam logic [3:0] S_QUE = 4'b0011;
  localparam logic [3:0] S_INP = 4'b0100;
  localparam logic [3:0] S_COR = 4'b0111;
  localparam logic [3:0] S_WRG = 4'b1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  factor_game_ctrl_if bus();

  factor_game_ctrl #(
    .Q_SHOW_CYC  (Q),
    .TIMEOUT_CYC (T),
    .HOLD_CYC    (H),
    .TW          (28)
  ) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] st;
    logic [3:0] que;
    logic [3:0] din;
    logic [3:0] score;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 0;

  int tgt_tbl[10] = '{6, 10, 15, 12, 21, 30, 35, 42, 18, 70};

  logic [3:0] m_st, m_que, m_din, m_score;
  int         m_acc;
  logic [3:0] p_st, p_que, p_din, p_sc;

  function automatic int prime_of(input int k);
    case (k)
      1: return 2;
      2: return 3;
      3: return 5;
      4: return 7;
      default: return 0;
    endcase
  endfunction

  function automatic void chk(input string name,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at edge %0d",
               name, act, exp, cyc);
    end
  endfunction

  function automatic void expect_out(input logic [3:0] st,
                                     input logic [3:0] q,
                                     input logic [3:0] d,
                                     input logic [3:0] s,
                                     input int at);
    exp_t e;
    if (st != m_st || q != m_que || d != m_din || s != m_score) begin
      e.st = st; e.que = q; e.din = d; e.score = s; e.at = at;
      sb.push_back(e);
    end
    m_st = st; m_que = q; m_din = d; m_score = s;
  endfunction

  function automatic void model_reset();
    m_st = S_RDY; m_que = 0; m_din = 0; m_score = 0; m_acc = 1;
    p_st = S_RDY; p_que = 0; p_din = 0; p_sc = 0;
  endfunction

  // monitor: any output change must match the next expectation
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus.STATE !== p_st || bus.QUE !== p_que ||
          bus.DIN !== p_din || bus.SCORE !== p_sc) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change: got st=%b que=%0d din=%0d score=%0d expected no change at edge %0d",
                   bus.STATE, bus.QUE, bus.DIN, bus.SCORE, cyc);
        end else begin
          e = sb.pop_front();
          chk("state", 32'(bus.STATE), 32'(e.st));
          chk("que",   32'(bus.QUE),   32'(e.que));
          chk("din",   32'(bus.DIN),   32'(e.din));
          chk("score", 32'(bus.SCORE), 32'(e.score));
          chk("edge",  32'(cyc),       32'(e.at));
        end
        p_st = bus.STATE; p_que = bus.QUE;
        p_din = bus.DIN; p_sc = bus.SCORE;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.START = 1'b0;
    bus.KEY_VALID = 1'b0;
    bus.KEY = 4'd0;
  endtask

  // idle until edge e; noise pulses must be ignored by the DUT
  task automatic wait_until(input int e, input bit noise,
                            input bit allow_start);
    while (cyc < e) begin
      bus.START = noise && allow_start && ($urandom_range(0, 2) == 0);
      bus.KEY_VALID = noise && ($urandom_range(0, 2) == 0);
      bus.KEY = 4'($urandom_range(0, 15));
      tick();
    end
    clear_in();
  endtask

  // one full round: start, question, key entries, hold
  task automatic play(input int keys[$], input int gaps[$],
                      input int pre);
    int e0, i0, last, dl, k, p, n, h;
    bit done;
    logic [3:0] nq, ns;
    done = 0;
    wait_until(cyc + pre, 1, 0);
    e0 = cyc + 1;
    expect_out(S_QUE, m_que, 0, m_score, e0);
    m_acc = 1;
    bus.START = 1'b1;
    tick();
    clear_in();
    i0 = e0 + Q;
    expect_out(S_INP, m_que, 0, m_score, i0);
    wait_until(i0, 1, 1);
    last = i0;
    dl = i0 + T;
    h = 0;
    for (int j = 0; j < keys.size() && !done; j++) begin
      k = last + gaps[j];
      if (k > dl) break;
      wait_until(k - 1, 0, 0);
      p = prime_of(keys[j]);
      n = m_acc * p;
      if (p == 0 || n > tgt_tbl[m_que]) begin
        expect_out(S_WRG, m_que, 4'(keys[j]), m_score, k);
        done = 1;
      end else if (n == tgt_tbl[m_que]) begin
        ns = (m_score == 15) ? 4'd15 : m_score + 4'd1;
        nq = (m_que == 9) ? 4'd0 : m_que + 4'd1;
        expect_out(S_COR, nq, 4'(keys[j]), ns, k);
        done = 1;
      end else begin
        m_acc = n;
        expect_out(S_INP, m_que, 4'(keys[j]), m_score, k);
      end
      bus.KEY_VALID = 1'b1;
      bus.KEY = 4'(keys[j]);
      tick();
      clear_in();
      last = k;
      dl = k + T;
      h = k;
    end
    if (!done) begin
      h = dl;
      expect_out(S_WRG, m_que, m_din, m_score, h);
      wait_until(h, 0, 0);
    end
    expect_out(S_RDY, m_que, m_din, m_score, h + H);
    wait_until(h + H, 1, 1);
  endtask

  task automatic factor_keys(input int q, output int ks[$]);
    int t, tmp, j;
    ks = {};
    t = tgt_tbl[q];
    for (int kc = 1; kc <= 4; kc++)
      while (t % prime_of(kc) == 0) begin
        ks.push_back(kc);
        t = t / prime_of(kc);
      end
    for (int i = ks.size() - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = ks[i]; ks[i] = ks[j]; ks[j] = tmp;
    end
  endtask

  task automatic rand_gaps(input int cnt, input int hi,
                           output int gs[$]);
    gs = {};
    for (int i = 0; i < cnt; i++)
      gs.push_back($urandom_range(1, hi));
  endtask

  // enter INPUT, accept one key, then pull reset between edges
  task automatic reset_mid_input();
    int e0;
    e0 = cyc + 1;
    expect_out(S_QUE, m_que, 0, m_score, e0);
    bus.START = 1'b1;
    tick();
    clear_in();
    expect_out(S_INP, m_que, 0, m_score, e0 + Q);
    wait_until(e0 + Q + 1, 0, 0);
    expect_out(S_INP, m_que, 1, m_score, e0 + Q + 2);
    bus.KEY_VALID = 1'b1;
    bus.KEY = 4'd1;
    tick();
    clear_in();
    tick();
    #2;
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    chk("async_state", 32'(bus.STATE), 32'(S_RDY));
    chk("async_que",   32'(bus.QUE),   32'd0);
    chk("async_din",   32'(bus.DIN),   32'd0);
    chk("async_score", 32'(bus.SCORE), 32'd0);
    sb.delete();
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    model_reset();
    mon_en = 1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kq[$], gq[$], none[$];
    clear_in();
    model_reset();
    repeat (3) tick();
    chk("rst_state", 32'(bus.STATE), 32'(S_RDY));
    chk("rst_que",   32'(bus.QUE),   32'd0);
    chk("rst_din",   32'(bus.DIN),   32'd0);
    chk("rst_score", 32'(bus.SCORE), 32'd0);
    #2 rst_n = 1'b1;
    mon_en = 1;
    tick();

    kq = '{1, 2}; gq = '{2, 3};
    play(kq, gq, 1);
    kq = '{4, 1}; gq = '{1, 1};
    play(kq, gq, 0);
    play(none, none, 2);
    kq = '{1, 3}; gq = '{T, T};
    play(kq, gq, 0);
    kq = '{0}; gq = '{3};
    play(kq, gq, 0);
    kq = '{9}; gq = '{1};
    play(kq, gq, 1);

    for (int r = 0; r < 20; r++) begin
      factor_keys(int'(m_que), kq);
      rand_gaps(kq.size(), 4, gq);
      play(kq, gq, $urandom_range(0, 3));
    end

    for (int r = 0; r < 12; r++) begin
      kq = {};
      for (int i = 0; i < $urandom_range(1, 4); i++)
        kq.push_back(($urandom_range(0, 5) == 0) ?
                     $urandom_range(0, 15) : $urandom_range(1, 4));
      rand_gaps(kq.size(), 10, gq);
      play(kq, gq, $urandom_range(0, 2));
    end

    reset_mid_input();
    factor_keys(0, kq);
    rand_gaps(kq.size(), 3, gq);
    play(kq, gq, 1);

    repeat (3) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
